// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return op[2] & op[1];
  endfunction

  // MUL keeps its low half identical either way, so it is handled as unsigned.
  function automatic logic is_signed_a(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {acc,q} pair: shift-add multiply (right shift)
// or restoring compare-subtract divide (left shift).
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] q_nxt
);

  logic [XLEN:0] sum, shl, diff;

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, opnd};
    shl     = {acc, q[XLEN-1]};
    diff    = shl - {1'b0, opnd};
    acc_nxt = acc;
    q_nxt   = q;
    if (is_div) begin
      // Partial remainder stays below the divisor, so XLEN+1 bits never overflow.
      if (shl >= {1'b0, opnd}) begin
        acc_nxt = diff[XLEN-1:0];
        q_nxt   = {q[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = shl[XLEN-1:0];
        q_nxt   = {q[XLEN-2:0], 1'b0};
      end
    end else if (q[0]) begin
      acc_nxt = sum[XLEN:1];
      q_nxt   = {sum[0], q[XLEN-1:1]};
    end else begin
      acc_nxt = {1'b0, acc[XLEN-1:1]};
      q_nxt   = {acc[0], q[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes on both sides.
// Optional MULDIV_EARLY_OUT_EN: trivial multiplies/divides complete at accept.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [2:0]      MulDivOp,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Result
);

  localparam int CNTW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   state, state_nxt;
  muldiv_op_e      op_in, op_q;
  logic [XLEN-1:0] acc, qr, opnd, acc_nxt, qr_nxt;
  logic [CNTW-1:0] cnt;
  logic            neg_q, neg_r, accept, step_div;
  logic            neg_a, neg_b, div0, ovf, early, special;
  logic [XLEN-1:0] abs_a, abs_b, spec_res, fin_res;
  logic [2*XLEN-1:0] prod;

  assign op_in    = muldiv_op_e'(MulDivOp);
  assign accept   = InValid && (state == IDLE) && !Flush;
  assign step_div = is_div(op_q);

  always_comb begin
    neg_a = is_signed_a(op_in) & SrcA[XLEN-1];
    neg_b = is_signed_b(op_in) & SrcB[XLEN-1];
    abs_a = neg_a ? -SrcA : SrcA;
    abs_b = neg_b ? -SrcB : SrcB;
    div0  = is_div(op_in) && (SrcB == '0);
    ovf   = is_div(op_in) && is_signed_b(op_in) && (SrcA == MIN) && (SrcB == '1);
`ifdef MULDIV_EARLY_OUT_EN
    early = is_div(op_in) ? (!div0 && (abs_a < abs_b)) : ((SrcA == '0) || (SrcB == '0));
`else
    early = 1'b0;
`endif
    special  = div0 || ovf || early;
    spec_res = '0;
    if (div0)                       spec_res = is_rem(op_in) ? SrcA : '1;
    else if (ovf)                   spec_res = is_rem(op_in) ? '0 : MIN;
    else if (early && is_div(op_in)) spec_res = is_rem(op_in) ? SrcA : '0;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (step_div),
    .acc    (acc),
    .q      (qr),
    .opnd   (opnd),
    .acc_nxt(acc_nxt),
    .q_nxt  (qr_nxt)
  );

  // Sign fixup on the final iteration's output, applied as it enters DONE.
  always_comb begin
    prod    = {acc_nxt, qr_nxt};
    fin_res = '0;
    if (step_div) begin
      if (is_rem(op_q)) fin_res = neg_r ? -acc_nxt : acc_nxt;
      else              fin_res = neg_q ? -qr_nxt  : qr_nxt;
    end else begin
      if (neg_q) prod = -prod;
      fin_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : BUSY;
      BUSY:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (OutReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (Flush) state_nxt = IDLE;
  end

  always_comb begin
    InReady  = (state == IDLE);
    OutValid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q   <= OP_MUL;
      acc    <= '0;
      qr     <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      Result <= '0;
    end else if (!Flush) begin
      if (accept) begin
        op_q  <= op_in;
        acc   <= '0;
        qr    <= is_div(op_in) ? abs_a : abs_b;
        opnd  <= is_div(op_in) ? abs_b : abs_a;
        neg_q <= neg_a ^ neg_b;
        neg_r <= neg_a;
        cnt   <= CNTW'(XLEN-1);
        if (special) Result <= spec_res;
      end else if (state == BUSY) begin
        acc <= acc_nxt;
        qr  <= qr_nxt;
        if (cnt == '0) Result <= fin_res;
        else           cnt    <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors, queue of expected results, decoupled monitor.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n, Flush, InValid, OutReady;
  logic        InReady, OutValid;
  logic [2:0]  MulDivOp;
  logic [31:0] SrcA, SrcB, Result;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] expq[$];

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .Flush(Flush),
    .InValid(InValid), .InReady(InReady), .MulDivOp(MulDivOp),
    .SrcA(SrcA), .SrcB(SrcB),
    .OutValid(OutValid), .OutReady(OutReady), .Result(Result)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation on every completed output handshake.
  always begin
    @(negedge clk);
    #1;
    if (reset_n && OutValid && OutReady) begin
      if (expq.size() == 0) begin
        chk("unexpected_result", Result, 32'hx);
      end else begin
        chk("scoreboard", Result, expq.pop_front());
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push, input int exp_lat, input bit wait_done);
    int guard = 0;
    int lat;
    bit rdy_seen;
    while (!InReady && guard < 200) begin @(negedge clk); guard++; end
    chk("inready_before_issue", {31'd0, InReady}, 32'd1);
    MulDivOp = op; SrcA = a; SrcB = b; InValid = 1'b1;
    @(posedge clk);
    if (push) expq.push_back(exp);
    @(negedge clk);
    InValid = 1'b0; SrcA = 32'hDEAD_BEEF; SrcB = 32'h1234_5678; MulDivOp = 3'd5;
    if (!wait_done) return;
    lat = 1; rdy_seen = 1'b0;
    while (!OutValid && lat < 100) begin
      if (InReady) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    if (exp_lat > 1) chk("inready_while_busy", {31'd0, rdy_seen}, 32'd0);
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    MulDivOp = 3'd0; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    chk("reset_inready", {31'd0, InReady}, 32'd1);
    chk("reset_outvalid", {31'd0, OutValid}, 32'd0);
    chk("reset_result", Result, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    issue(3'd0, 32'd7,          32'd6,          32'd42,         1, 33, 1);
    issue(3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  1, 33, 1);
    issue(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1, 33, 1);
    issue(3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  1, 33, 1);
    issue(3'd0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  1, 33, 1);
    issue(3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1, 33, 1);
    issue(3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1, 33, 1);
    issue(3'd5, 32'd100,        32'd7,          32'd14,         1, 33, 1);
    issue(3'd7, 32'd100,        32'd7,          32'd2,          1, 33, 1);
    issue(3'd5, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1, 33, 1);
    issue(3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF,  1, 1,  1);
    issue(3'd6, 32'd5,          32'd0,          32'd5,          1, 1,  1);
    issue(3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1, 1,  1);
    issue(3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1, 1,  1);

    // Consumer stalls for 5 cycles in DONE.
    @(negedge clk);
    OutReady = 1'b0;
    issue(3'd5, 32'd100, 32'd7, 32'd14, 1, 33, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_outvalid", {31'd0, OutValid}, 32'd1);
      chk("stall_result", Result, 32'd14);
    end
    OutReady = 1'b1;
    @(negedge clk);
    chk("release_inready", {31'd0, InReady}, 32'd1);
    chk("release_outvalid", {31'd0, OutValid}, 32'd0);

    // Flush at iteration 10 of a DIVU; same-edge InValid must be dropped.
    issue(3'd5, 32'd1000, 32'd3, 32'd0, 0, 0, 0);
    repeat (9) @(negedge clk);
    Flush = 1'b1; InValid = 1'b1; MulDivOp = 3'd0; SrcA = 32'd2; SrcB = 32'd2;
    @(negedge clk);
    Flush = 1'b0; InValid = 1'b0;
    chk("flush_inready", {31'd0, InReady}, 32'd1);
    chk("flush_outvalid", {31'd0, OutValid}, 32'd0);
    chk("flush_result_kept", Result, 32'd14);
    @(negedge clk);
    chk("flush_invalid_ignored", {31'd0, InReady}, 32'd1);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (OutValid) seen = 1'b1; end
    chk("flush_no_outvalid", {31'd0, seen}, 32'd0);

    // Reset in the middle of a MUL.
    issue(3'd0, 32'd123, 32'd456, 32'd0, 0, 0, 0);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midreset_inready", {31'd0, InReady}, 32'd1);
    chk("midreset_outvalid", {31'd0, OutValid}, 32'd0);
    chk("midreset_result", Result, 32'd0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (OutValid) seen = 1'b1; end
    chk("midreset_no_outvalid", {31'd0, seen}, 32'd0);

    issue(3'd0, 32'd3, 32'd3, 32'd9, 1, 33, 1);

    for (int i = 0; i < 10 && expq.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", expq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
